// File: rtl/sici_pcs_syn_ml.sv
// ---------------------------------------------------------------------------
// sici_pcs_syn_ml
// Multi-lane PCS block-lock. Each lane runs an independent sync-header hunt
// FSM (HUNT / SLIP / SYNC / SH_ERR), requests bit slips from the
// deserialiser, tracks a slip-limit fault and counts SH errors while locked.
//
// Ports
//   Ck        clock
//   Rs        asynchronous active-high reset
//   CE        clock enable; all registers hold when low
//   Phy_Dat   LN lanes of FW-bit frames, SH in bits [FW-1:FW-2] of each lane
//   Re_Syn    per-lane resync request (rising edge, asynchronous source)
//   Cnt_Clr   synchronous clear of the error counters
//   Bit_Slp   per-lane one-cycle slip pulse
//   PCS_Dat   Phy_Dat registered once
//   Syn_OK    per-lane lock flag (SYNC or SH_ERR)
//   All_OK    every lane locked
//   Err_SH    per-lane SH_ERR flag
//   Lane_Flt  per-lane slip-limit fault
//   Err_Cnt   per-lane ECW-bit saturating SH error counts
// ---------------------------------------------------------------------------
module sici_pcs_syn_ml #(
    parameter int LN  = 4,
    parameter int FW  = 66,
    parameter int SWT = 64,
    parameter int ENT = 32,
    parameter int EXT = 4,
    parameter int MXS = 16,
    parameter int ECW = 8
) (
    input  logic              Ck,
    input  logic              Rs,
    input  logic              CE,
    input  logic [LN*FW-1:0]  Phy_Dat,
    input  logic [LN-1:0]     Re_Syn,
    input  logic              Cnt_Clr,
    output logic [LN-1:0]     Bit_Slp,
    output logic [LN*FW-1:0]  PCS_Dat,
    output logic [LN-1:0]     Syn_OK,
    output logic              All_OK,
    output logic [LN-1:0]     Err_SH,
    output logic [LN-1:0]     Lane_Flt,
    output logic [LN*ECW-1:0] Err_Cnt
);

    // State counter must reach the largest threshold; it may wrap in SYNC,
    // where its value is never used.
    localparam int MXC = (SWT > ENT) ? SWT : ENT;
    localparam int CW  = $clog2(MXC + 2);
    localparam int SCW = $clog2(MXS + 1);

    localparam logic [CW-1:0]  SWT_C = CW'(SWT);
    localparam logic [CW-1:0]  ENT_C = CW'(ENT);
    localparam logic [CW-1:0]  EXT_C = CW'(EXT);
    localparam logic [SCW-1:0] MXS_C = SCW'(MXS);
    localparam logic [ECW-1:0] EMAX  = '1;

    typedef enum logic [1:0] {HUNT, SLIP, SYNC, SH_ERR} state_t;

    state_t         st   [LN];
    state_t         nxt  [LN];
    logic [CW-1:0]  cnt  [LN];
    logic [SCW-1:0] slc  [LN];

    logic [LN-1:0] rs_m, rs_s, rs_d, rs_edge;
    logic [LN-1:0] sh_ok, in_sync, in_err, err_ev, to_slip, to_sync;

    always_comb begin
        rs_edge = rs_s & ~rs_d;
        sh_ok   = '0;
        in_sync = '0;
        in_err  = '0;
        err_ev  = '0;
        to_slip = '0;
        to_sync = '0;
        for (int unsigned i = 0; i < LN; i++) begin
            sh_ok[i]   = Phy_Dat[i*FW+FW-1] ^ Phy_Dat[i*FW+FW-2];
            in_sync[i] = (st[i] == SYNC) || (st[i] == SH_ERR);
            in_err[i]  = (st[i] == SH_ERR);
            err_ev[i]  = in_sync[i] & ~sh_ok[i];
            nxt[i]     = st[i];
            case (st[i])
                HUNT: begin
                    if (!sh_ok[i])
                        nxt[i] = SLIP;
                    else if (cnt[i] >= ENT_C)
                        nxt[i] = SYNC;
                end
                SLIP: begin
                    if (cnt[i] >= SWT_C)
                        nxt[i] = HUNT;
                end
                SYNC: begin
                    if (!sh_ok[i])
                        nxt[i] = SH_ERR;
                end
                SH_ERR: begin
                    if (sh_ok[i])
                        nxt[i] = SYNC;
                    else if (cnt[i] >= EXT_C)
                        nxt[i] = SLIP;
                end
                default: nxt[i] = HUNT;
            endcase
            to_slip[i] = (nxt[i] == SLIP) && (st[i] != SLIP);
            to_sync[i] = (nxt[i] == SYNC) && (st[i] != SYNC);
        end
    end

    always_ff @(posedge Ck or posedge Rs) begin
        if (Rs) begin
            for (int unsigned i = 0; i < LN; i++) begin
                st[i]  <= HUNT;
                cnt[i] <= '0;
                slc[i] <= '0;
            end
            rs_m     <= '0;
            rs_s     <= '0;
            rs_d     <= '0;
            Bit_Slp  <= '0;
            PCS_Dat  <= '0;
            Syn_OK   <= '0;
            All_OK   <= 1'b0;
            Err_SH   <= '0;
            Lane_Flt <= '0;
            Err_Cnt  <= '0;
        end else if (CE) begin
            rs_m    <= Re_Syn;
            rs_s    <= rs_m;
            rs_d    <= rs_s;
            PCS_Dat <= Phy_Dat;
            Syn_OK  <= in_sync;
            Err_SH  <= in_err;
            All_OK  <= &in_sync;
            for (int unsigned i = 0; i < LN; i++) begin
                Bit_Slp[i] <= (st[i] == SLIP) && (cnt[i] == '0) && !rs_edge[i];

                // Clear wins over the count, but an error in the same cycle
                // is still recorded.
                if (Cnt_Clr)
                    Err_Cnt[i*ECW +: ECW] <= {{(ECW-1){1'b0}}, err_ev[i]};
                else if (err_ev[i] && (Err_Cnt[i*ECW +: ECW] != EMAX))
                    Err_Cnt[i*ECW +: ECW] <= Err_Cnt[i*ECW +: ECW] + 1'b1;

                if (rs_edge[i]) begin
                    st[i]       <= HUNT;
                    cnt[i]      <= '0;
                    slc[i]      <= '0;
                    Lane_Flt[i] <= 1'b0;
                end else begin
                    st[i]  <= nxt[i];
                    cnt[i] <= (nxt[i] != st[i]) ? '0 : cnt[i] + 1'b1;
                    if (to_sync[i]) begin
                        slc[i]      <= '0;
                        Lane_Flt[i] <= 1'b0;
                    end else if (to_slip[i] && (slc[i] != MXS_C)) begin
                        slc[i] <= slc[i] + 1'b1;
                        if (slc[i] + 1'b1 == MXS_C)
                            Lane_Flt[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
